// File: rtl/wash_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | wash_scheduler_if : kiosk request / washer control bundle                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface wash_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_double;
  logic               wash_done;
  logic               coin_in;
  logic               double_wash;
  logic [NUM_REQ-1:0] pending;
  logic               busy;
  logic [IDW-1:0]     active_id;
  logic               done_valid;
  logic [IDW-1:0]     done_id;
  logic               done_fault;

  modport master (
    output req, req_double, wash_done,
    input  coin_in, double_wash, pending, busy, active_id,
    input  done_valid, done_id, done_fault
  );

  modport slave (
    input  req, req_double, wash_done,
    output coin_in, double_wash, pending, busy, active_id,
    output done_valid, done_id, done_fault
  );
endinterface

`default_nettype wire

// File: rtl/wash_scheduler.sv
// +----------------------------------------------------------------------------+
// | wash_scheduler : round-robin sharing of one washer among NUM_REQ kiosks     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wash_scheduler #(
  parameter int NUM_REQ           = 4,
  parameter int COIN_PULSE_CYCLES = 5,
  parameter int GAP_CYCLES        = 16,
  parameter int MAX_RUN_CYCLES    = 65535
) (
  input  wire logic          clk,
  input  wire logic          rst,
  wash_scheduler_if.slave    wb
);
  localparam int          IDW         = $clog2(NUM_REQ);
  localparam logic [31:0] c_coin_last = 32'(COIN_PULSE_CYCLES - 1);
  localparam logic [31:0] c_run_last  = 32'(MAX_RUN_CYCLES - 1);
  localparam logic [31:0] c_gap_last  = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COIN = 2'd1,
    S_RUN  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t             r_state,       w_state;
  logic [NUM_REQ-1:0] r_pending,     w_pending;
  logic [NUM_REQ-1:0] r_dbl,         w_dbl;
  logic [IDW-1:0]     r_rr_ptr,      w_rr_ptr;
  logic [IDW-1:0]     r_active_id,   w_active_id;
  logic               r_double_wash, w_double_wash;
  logic [31:0]        r_coin_cnt,    w_coin_cnt;
  logic [31:0]        r_wait_cnt,    w_wait_cnt;
  logic [31:0]        r_gap_cnt,     w_gap_cnt;
  logic               r_done_valid,  w_done_valid;
  logic [IDW-1:0]     r_done_id,     w_done_id;
  logic               r_done_fault,  w_done_fault;
  logic               r_wash_done_q;

  logic               w_busy;
  logic               w_rise;
  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic [IDW-1:0]     w_idx;

  assign w_busy = (r_state != S_IDLE);
  assign w_rise = wb.wash_done && !r_wash_done_q;

  // Round-robin scan of the registered pending flags starting at r_rr_ptr
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && r_pending[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state       = r_state;
    w_pending     = r_pending;
    w_dbl         = r_dbl;
    w_rr_ptr      = r_rr_ptr;
    w_active_id   = r_active_id;
    w_double_wash = r_double_wash;
    w_coin_cnt    = r_coin_cnt;
    w_wait_cnt    = r_wait_cnt;
    w_gap_cnt     = r_gap_cnt;
    w_done_valid  = 1'b0;
    w_done_id     = r_done_id;
    w_done_fault  = 1'b0;

    // Duplicate requests (already pending, or for the kiosk being served) are dropped
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wb.req[i] && !r_pending[i] && !(w_busy && (r_active_id == IDW'(i)))) begin
        w_pending[i] = 1'b1;
        w_dbl[i]     = wb.req_double[i];
      end
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_active_id         = w_winner;
          w_pending[w_winner] = 1'b0;
          w_double_wash       = r_dbl[w_winner];
          w_rr_ptr            = IDW'((int'(w_winner) + 1) % NUM_REQ);
          w_coin_cnt          = '0;
          w_state             = S_COIN;
        end
      end
      S_COIN: begin
        if (r_coin_cnt == c_coin_last) begin
          w_wait_cnt = '0;
          w_state    = S_RUN;
        end else begin
          w_coin_cnt = r_coin_cnt + 32'd1;
        end
      end
      S_RUN: begin
        // A done edge beats a simultaneous watchdog expiry
        if (w_rise || (r_wait_cnt == c_run_last)) begin
          w_done_valid  = 1'b1;
          w_done_fault  = !w_rise;
          w_done_id     = r_active_id;
          w_double_wash = 1'b0;
          w_gap_cnt     = '0;
          w_state       = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          w_wait_cnt = r_wait_cnt + 32'd1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_gap_last) begin
          w_state = S_IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt + 32'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_dbl         <= '0;
      r_rr_ptr      <= '0;
      r_active_id   <= '0;
      r_double_wash <= 1'b0;
      r_coin_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_done_valid  <= 1'b0;
      r_done_id     <= '0;
      r_done_fault  <= 1'b0;
      r_wash_done_q <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_pending     <= w_pending;
      r_dbl         <= w_dbl;
      r_rr_ptr      <= w_rr_ptr;
      r_active_id   <= w_active_id;
      r_double_wash <= w_double_wash;
      r_coin_cnt    <= w_coin_cnt;
      r_wait_cnt    <= w_wait_cnt;
      r_gap_cnt     <= w_gap_cnt;
      r_done_valid  <= w_done_valid;
      r_done_id     <= w_done_id;
      r_done_fault  <= w_done_fault;
      r_wash_done_q <= wb.wash_done;
    end
  end

  assign wb.coin_in     = (r_state == S_COIN);
  assign wb.double_wash = r_double_wash;
  assign wb.pending     = r_pending;
  assign wb.busy        = w_busy;
  assign wb.active_id   = r_active_id;
  assign wb.done_valid  = r_done_valid;
  assign wb.done_id     = r_done_id;
  assign wb.done_fault  = r_done_fault;
endmodule

`default_nettype wire

// File: tb/tb_wash_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_wash_scheduler : directed scoreboard bench for wash_scheduler            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wash_scheduler;
  localparam int NREQ   = 4;
  localparam int COIN   = 5;
  localparam int GAP    = 16;
  localparam int MAXRUN = 100;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   grant_q[$];   // id*2 + double option
  int   done_q[$];    // id*2 + fault

  wash_scheduler_if #(.NUM_REQ(NREQ)) wb ();

  wash_scheduler #(
    .NUM_REQ(NREQ), .COIN_PULSE_CYCLES(COIN),
    .GAP_CYCLES(GAP), .MAX_RUN_CYCLES(MAXRUN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops expected grants/completions and watches coin pulse and gap
  int  coin_len = 0;
  bit  prev_coin = 0;
  bit  prev_dv = 0;
  int  gap_left = 0;
  bit  gap_armed = 0;
  bit  gap_bad = 0;
  always @(negedge clk) begin
    if (rst) begin
      coin_len = 0; prev_coin = 0; prev_dv = 0;
      gap_left = 0; gap_armed = 0; gap_bad = 0;
    end else begin
      if (wb.coin_in && !prev_coin) begin
        check("grant_expected", grant_q.size() != 0, 1);
        if (grant_q.size() != 0) begin
          int g;
          g = grant_q.pop_front();
          check("grant_id", wb.active_id, g / 2);
          check("grant_dbl", wb.double_wash, g % 2);
        end
      end
      if (wb.coin_in) coin_len++;
      else if (prev_coin) begin
        check("coin_len", coin_len, COIN);
        coin_len = 0;
      end
      if (prev_dv) check("done_one_cycle", wb.done_valid, 0);
      if (wb.done_valid) begin
        done_cnt++;
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          int d;
          d = done_q.pop_front();
          check("done_id", wb.done_id, d / 2);
          check("done_fault", wb.done_fault, d % 2);
        end
        check("dw_cleared", wb.double_wash, 0);
        gap_left = GAP; gap_armed = 1; gap_bad = 0;
      end
      if (gap_left > 0) begin
        if (wb.coin_in || !wb.busy) gap_bad = 1;
        gap_left--;
      end else if (gap_armed) begin
        check("gap_clean", gap_bad, 0);
        check("idle_after_gap", wb.busy, 0);
        gap_armed = 0;
      end
      prev_coin = wb.coin_in;
      prev_dv   = wb.done_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req_pulse(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] dbl);
    wb.req = mask; wb.req_double = dbl;
    tick();
    wb.req = '0; wb.req_double = '0;
  endtask

  task automatic wait_run();
    int n = 0;
    bit seen = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (wb.coin_in) seen = 1;
      else if (seen) break;
    end
    check("run_entry", seen && !wb.coin_in, 1);
  endtask

  task automatic wait_done(input int limit, output int cycles);
    int start;
    start = done_cnt;
    cycles = 0;
    while (done_cnt == start && cycles < limit) begin
      @(negedge clk); #1;
      cycles++;
    end
    check("done_seen", done_cnt - start, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (wb.busy && n < 200);
    check("reach_idle", wb.busy, 0);
  endtask

  task automatic finish_run();
    int c;
    wait_run();
    repeat (3) begin @(negedge clk); #1; end
    wb.wash_done = 1'b1;
    wait_done(50, c);
    wb.wash_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int c;
    rst = 1'b1;
    wb.req = '0; wb.req_double = '0; wb.wash_done = 1'b0;
    repeat (3) tick();
    check("rst_coin", wb.coin_in, 0);
    check("rst_pending", wb.pending, 0);
    check("rst_busy", wb.busy, 0);
    check("rst_active", wb.active_id, 0);
    check("rst_dv", wb.done_valid, 0);
    check("rst_done_id", wb.done_id, 0);
    check("rst_fault", wb.done_fault, 0);
    check("rst_dw", wb.double_wash, 0);
    rst = 1'b0;
    tick();

    // Single double-wash request from kiosk 2
    grant_q.push_back(2 * 2 + 1); done_q.push_back(2 * 2 + 0);
    req_pulse(4'b0100, 4'b0100);
    check("t1_pending", wb.pending, 4'b0100);
    check("t1_no_coin_yet", wb.coin_in, 0);
    tick();
    check("t1_coin", wb.coin_in, 1);
    check("t1_active", wb.active_id, 2);
    check("t1_dw", wb.double_wash, 1);
    check("t1_busy", wb.busy, 1);
    check("t1_pending_clr", wb.pending, 0);
    wait_run();
    check("t1_dw_in_run", wb.double_wash, 1);
    @(negedge clk); #1;
    wb.wash_done = 1'b1;
    wait_done(50, c);
    wb.wash_done = 1'b0;
    wait_idle();

    // Fresh reset so rr_ptr=0, then three simultaneous requests
    rst = 1'b1; tick(); rst = 1'b0; tick();
    grant_q.push_back(0 * 2 + 0); grant_q.push_back(1 * 2 + 1); grant_q.push_back(3 * 2 + 1);
    done_q.push_back(0); done_q.push_back(2); done_q.push_back(6);
    req_pulse(4'b1011, 4'b1010);
    repeat (3) finish_run();
    wait_idle();

    // Re-requests while pending and while active are dropped
    grant_q.push_back(0 * 2 + 0); grant_q.push_back(1 * 2 + 1);
    done_q.push_back(0); done_q.push_back(2);
    req_pulse(4'b0011, 4'b0010);
    tick();
    req_pulse(4'b0010, 4'b0000);
    check("t4_pending_kept", wb.pending, 4'b0010);
    finish_run();
    wait_run();
    req_pulse(4'b0010, 4'b0000);
    check("t4_active_dropped", wb.pending, 4'b0000);
    @(negedge clk); #1;
    wb.wash_done = 1'b1;
    wait_done(50, c);
    wb.wash_done = 1'b0;
    wait_idle();
    repeat (5) tick();
    check("t4_no_extra", wb.pending, 4'b0000);
    check("t4_idle", wb.busy, 0);

    // Watchdog with wash_done low, then with wash_done already high at RUN entry
    grant_q.push_back(3 * 2 + 0); done_q.push_back(3 * 2 + 1);
    req_pulse(4'b1000, 4'b0000);
    wait_run();
    wait_done(150, c);
    check("t5_wd_cycles", c, MAXRUN);
    wait_idle();
    grant_q.push_back(0 * 2 + 1); done_q.push_back(0 * 2 + 1);
    req_pulse(4'b0001, 4'b0001);
    tick();
    wb.wash_done = 1'b1;
    wait_run();
    wait_done(150, c);
    check("t5_level_not_edge", c, MAXRUN);
    wb.wash_done = 1'b0;
    wait_idle();

    // Reset in the third coin cycle
    grant_q.push_back(0 * 2 + 0);
    req_pulse(4'b0001, 4'b0000);
    tick(); tick(); tick();
    check("t6_coin_before", wb.coin_in, 1);
    rst = 1'b1;
    #1;
    check("t6_coin_rst", wb.coin_in, 0);
    check("t6_pending_rst", wb.pending, 0);
    check("t6_busy_rst", wb.busy, 0);
    tick();
    rst = 1'b0;
    tick();
    grant_q.push_back(1 * 2 + 0); done_q.push_back(1 * 2 + 0);
    req_pulse(4'b0010, 4'b0000);
    finish_run();
    wait_idle();

    check("grant_q_empty", grant_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
